// File: rtl/param_tfhe_pkg.sv
// TFHE parameter set shared by the PBS pipe.
// Constants only: no logic, no latency.
// Not applicable: this package has no handshake.
package param_tfhe_pkg;

    localparam int N          = 2048;
    localparam int LWE_K      = 24;
    localparam int MOD_Q_W    = 64;
    localparam logic [MOD_Q_W:0] MOD_Q = {1'b1, {MOD_Q_W{1'b0}}};

    // Switched coefficients live in [0, 2N).
    localparam int LWE_COEF_W = $clog2(2 * N);
    localparam int LWE_K_P1_W = $clog2(LWE_K + 1);

    // Number of low bits dropped by the modulus switch.
    localparam int MS_SHIFT     = MOD_Q_W - LWE_COEF_W;
    // The body is the coefficient that follows the LWE_K mask coefficients.
    localparam int LWE_BODY_IDX = LWE_K;

endpackage

// File: rtl/pep_ms_pkg.sv
// Types shared between the modulus-switch stage and its output buffer.
// Constants and types only: no latency.
// Not applicable: this package has no handshake.
package pep_ms_pkg;

    import param_tfhe_pkg::*;

    localparam int MS_PID_W = 5;

    // One switched coefficient with its ciphertext context.
    typedef struct packed {
        logic [LWE_COEF_W-1:0] coef;
        logic [MS_PID_W-1:0]   pid;
        logic [LWE_K_P1_W-1:0] idx;
        logic                  body;
    } ms_data_t;

endpackage

// File: rtl/pep_ms_ofifo.sv
// Register-based show-ahead FIFO of ms_data_t with an occupancy count.
// Latency: a write is visible on rd_dat/rd_vld the cycle after it is taken.
// Backpressure: the writer must not push when full; rd_rdy low holds rd_dat stable.
// Ports: clk, a_rst_n; wr_vld/wr_dat push side; rd_vld/rd_rdy/rd_dat pop side;
//        cnt is the current number of stored entries.
module pep_ms_ofifo
    import pep_ms_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             a_rst_n,
    input  logic             wr_vld,
    input  ms_data_t         wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output ms_data_t         rd_dat,
    output logic [CNT_W-1:0] cnt
);

    localparam int PTR_W = $clog2(DEPTH);

    ms_data_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign push   = wr_vld;
    assign pop    = rd_vld && rd_rdy;
    assign rd_vld = (cnt != '0);
    assign rd_dat = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: cnt alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/pep_mod_switch.sv
// Modulus switch: rounds LWE coefficients from MOD_Q_W to LWE_COEF_W bits, tags index/body/pid.
// Latency: accept at cycle t gives out_vld at t+2 into an empty buffer; 1 coefficient/cycle.
// Backpressure: in_rdy drops once buffer plus stage S1 hold OUT_DEPTH entries; out_* hold while stalled.
// Ports: clk, a_rst_n; in_coef/in_pid/in_vld/in_rdy input stream;
//        out_coef/out_pid/out_idx/out_body/out_vld/out_rdy output stream;
//        err_pid pulses one cycle after a mid-ciphertext pid change.
module pep_mod_switch
    import param_tfhe_pkg::*;
    import pep_ms_pkg::*;
#(
    parameter int PID_W     = MS_PID_W,
    parameter int OUT_DEPTH = 4,
    parameter int BODY_NEG  = 1
) (
    input  logic                  clk,
    input  logic                  a_rst_n,
    input  logic [MOD_Q_W-1:0]    in_coef,
    input  logic [PID_W-1:0]      in_pid,
    input  logic                  in_vld,
    output logic                  in_rdy,
    output logic [LWE_COEF_W-1:0] out_coef,
    output logic [PID_W-1:0]      out_pid,
    output logic [LWE_K_P1_W-1:0] out_idx,
    output logic                  out_body,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic                  err_pid
);

    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    if (MOD_Q != {1'b1, {MOD_Q_W{1'b0}}}) begin : g_bad_mod_q
        $fatal(1, "pep_mod_switch: MOD_Q must equal 2**MOD_Q_W");
    end
    if (MS_SHIFT < 1) begin : g_bad_shift
        $fatal(1, "pep_mod_switch: MOD_Q_W must exceed LWE_COEF_W");
    end
    if (PID_W != MS_PID_W) begin : g_bad_pid_w
        $fatal(1, "pep_mod_switch: PID_W must match ms_data_t pid width");
    end
    if (OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "pep_mod_switch: OUT_DEPTH must be a power of two >= 2");
    end

    logic [CNT_W-1:0]      fifo_cnt;
    logic                  s1_vld;
    ms_data_t              s1_dat;
    ms_data_t              fifo_dat;
    logic [LWE_K_P1_W-1:0] idx_q;
    logic [PID_W-1:0]      pid_q;
    logic                  accept;
    logic                  is_first;
    logic                  is_body;
    logic [LWE_COEF_W-1:0] rnd;
    logic [LWE_COEF_W-1:0] sw_coef;
    logic [PID_W-1:0]      pid_sel;
    logic                  unused_coef;

    // S1 is counted as occupied so that its unconditional write next cycle
    // always finds a free slot. Gated by reset so nothing is offered while held.
    assign in_rdy = a_rst_n && ((fifo_cnt + CNT_W'(s1_vld)) < CNT_W'(OUT_DEPTH));
    assign accept = in_vld && in_rdy;

    // Round to nearest: top bits plus the first dropped bit; a carry out of
    // the top wraps to 0, which is the same point on the torus.
    assign rnd         = in_coef[MOD_Q_W-1:MS_SHIFT] + LWE_COEF_W'(in_coef[MS_SHIFT-1]);
    assign unused_coef = ^in_coef;

    assign is_first = (idx_q == '0);
    assign is_body  = (idx_q == LWE_K_P1_W'(LWE_BODY_IDX));
    assign sw_coef  = (is_body && BODY_NEG != 0) ? (LWE_COEF_W'(0) - rnd) : rnd;
    // Index 0 carries its own pid; later coefficients reuse the latched one
    // so a stray pid change never leaks downstream.
    assign pid_sel  = is_first ? in_pid : pid_q;

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            s1_vld  <= 1'b0;
            s1_dat  <= '0;
            idx_q   <= '0;
            pid_q   <= '0;
            err_pid <= 1'b0;
        end else begin
            s1_vld  <= accept;
            err_pid <= accept && !is_first && (in_pid != pid_q);
            if (accept) begin
                s1_dat <= '{coef: sw_coef, pid: pid_sel, idx: idx_q, body: is_body};
                idx_q  <= is_body ? '0 : idx_q + LWE_K_P1_W'(1);
                if (is_first) pid_q <= in_pid;
            end
        end
    end

    pep_ms_ofifo #(
        .DEPTH (OUT_DEPTH),
        .CNT_W (CNT_W)
    ) u_ofifo (
        .clk     (clk),
        .a_rst_n (a_rst_n),
        .wr_vld  (s1_vld),
        .wr_dat  (s1_dat),
        .rd_vld  (out_vld),
        .rd_rdy  (out_rdy),
        .rd_dat  (fifo_dat),
        .cnt     (fifo_cnt)
    );

    assign out_coef = fifo_dat.coef;
    assign out_pid  = fifo_dat.pid;
    assign out_idx  = fifo_dat.idx;
    assign out_body = fifo_dat.body;

endmodule

// File: tb/tb_pep_mod_switch.sv
// Bench for pep_mod_switch: directed and random streams against a queue-based reference.
// Latency and throughput are measured from recorded handshake cycles.
// Output backpressure is driven both held-low and randomly toggled.
module tb_pep_mod_switch;

    import param_tfhe_pkg::*;

    localparam int KP1       = LWE_K + 1;
    localparam int OUT_DEPTH = 4;
    localparam int MODV      = 1 << LWE_COEF_W;

    typedef struct {
        int coef;
        int pid;
        int idx;
        int body;
        int cyc;
    } rec_t;

    logic                  clk = 1'b0;
    logic                  a_rst_n;
    logic [MOD_Q_W-1:0]    in_coef;
    logic [4:0]            in_pid;
    logic                  in_vld;
    logic                  in_rdy;
    logic [LWE_COEF_W-1:0] out_coef;
    logic [4:0]            out_pid;
    logic [LWE_K_P1_W-1:0] out_idx;
    logic                  out_body;
    logic                  out_vld;
    logic                  out_rdy;
    logic                  err_pid;

    int   vec_cnt   = 0;
    int   miss_cnt  = 0;
    int   cyc       = 0;
    int   acc_cnt   = 0;
    int   err_seen  = 0;
    int   stab_viol = 0;
    int   m_idx     = 0;
    int   m_pid     = 0;
    bit   rand_rdy  = 1'b0;
    rec_t exp_q[$];
    rec_t got_q[$];
    logic stall_prev = 1'b0;
    logic [LWE_COEF_W+5+LWE_K_P1_W:0] prev_out;

    always #5 clk = ~clk;

    pep_mod_switch dut (
        .clk      (clk),
        .a_rst_n  (a_rst_n),
        .in_coef  (in_coef),
        .in_pid   (in_pid),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .out_coef (out_coef),
        .out_pid  (out_pid),
        .out_idx  (out_idx),
        .out_body (out_body),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .err_pid  (err_pid)
    );

    // Reference model and recorder. Inputs change #1 after posedge, so the
    // negedge view is exactly what the next posedge will act on.
    always @(negedge clk) begin
        rec_t e;
        int   r;
        cyc++;
        if (a_rst_n) begin
            if (in_vld && in_rdy) begin
                r = int'(in_coef >> MS_SHIFT) + int'((in_coef >> (MS_SHIFT - 1)) & 64'd1);
                r = r % MODV;
                if (m_idx == 0) m_pid = int'(in_pid);
                if (m_idx == LWE_K) r = (MODV - r) % MODV;
                e = '{coef: r, pid: m_pid, idx: m_idx, body: (m_idx == LWE_K) ? 1 : 0, cyc: cyc};
                exp_q.push_back(e);
                m_idx = (m_idx == LWE_K) ? 0 : m_idx + 1;
                acc_cnt++;
            end
            if (out_vld && out_rdy)
                got_q.push_back('{coef: int'(out_coef), pid: int'(out_pid), idx: int'(out_idx),
                                  body: int'(out_body), cyc: cyc});
            if (err_pid) err_seen++;
            if (stall_prev && {out_coef, out_pid, out_idx, out_body} !== prev_out) stab_viol++;
            stall_prev = out_vld && !out_rdy;
            prev_out   = {out_coef, out_pid, out_idx, out_body};
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send(input logic [MOD_Q_W-1:0] c, input logic [4:0] p);
        bit acc;
        int n;
        in_coef = c;
        in_pid  = p;
        in_vld  = 1'b1;
        n       = 0;
        do begin
            @(negedge clk);
            acc = in_rdy;
            @(posedge clk);
            #1;
            if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
            n++;
        end while (!acc && n < 300);
        in_vld = 1'b0;
        vec_cnt++;
        if (!acc) begin
            miss_cnt++;
            $display("FAIL send_accept: no accept after %0d cycles, required accept", n);
        end
    endtask

    task automatic send_ct(input logic [4:0] p, input int n);
        for (int i = 0; i < n; i++) send({$urandom, $urandom}, p);
    endtask

    task automatic drain(output bit ok);
        int n = 0;
        while ((got_q.size() < exp_q.size() || out_vld) && n < 500) begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
            n++;
        end
        ok = (n < 500);
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0;
        in_vld  = 1'b0;
        in_coef = '0;
        in_pid  = '0;
        out_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vec_cnt += 3;
        if (out_vld !== 1'b0) begin miss_cnt++; $display("FAIL rst_out_vld got %b want 0", out_vld); end
        if (in_rdy !== 1'b0)  begin miss_cnt++; $display("FAIL rst_in_rdy got %b want 0", in_rdy); end
        if (err_pid !== 1'b0) begin miss_cnt++; $display("FAIL rst_err_pid got %b want 0", err_pid); end
        @(negedge clk);
        a_rst_n = 1'b1;
        #1;
        vec_cnt += 2;
        if (in_rdy !== 1'b1)  begin miss_cnt++; $display("FAIL rel_in_rdy got %b want 1", in_rdy); end
        if (out_vld !== 1'b0) begin miss_cnt++; $display("FAIL rel_out_vld got %b want 0", out_vld); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_rounding();
        logic [MOD_Q_W-1:0] vals [4];
        int                 want [4];
        bit                 ok;
        vals[0] = 64'h0008_0000_0000_0000; want[0] = 'h001;
        vals[1] = 64'h0007_FFFF_FFFF_FFFF; want[1] = 'h000;
        vals[2] = 64'hFFF8_0000_0000_0000; want[2] = 'h000;
        vals[3] = 64'hFFF0_0000_0000_0000; want[3] = 'hFFF;
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) send(vals[i], 5'd2);
        send_ct(5'd2, KP1 - 4);
        drain(ok);
        vec_cnt++;
        if (!ok || got_q.size() != KP1) begin
            miss_cnt++;
            $display("FAIL rnd_count got %0d outputs want %0d", got_q.size(), KP1);
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            vec_cnt++;
            if (got_q[i].coef !== want[i] || got_q[i].idx !== i) begin
                miss_cnt++;
                $display("FAIL rnd_vec[%0d] got coef=%03h idx=%0d want coef=%03h idx=%0d",
                         i, got_q[i].coef, got_q[i].idx, want[i], i);
            end
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vec_cnt++;
            if (got_q[i].coef !== exp_q[i].coef || got_q[i].pid !== exp_q[i].pid ||
                got_q[i].idx !== exp_q[i].idx || got_q[i].body !== exp_q[i].body) begin
                miss_cnt++;
                $display("FAIL rnd_model[%0d] got %03h/%0d/%0d/%0d want %03h/%0d/%0d/%0d", i,
                         got_q[i].coef, got_q[i].pid, got_q[i].idx, got_q[i].body,
                         exp_q[i].coef, exp_q[i].pid, exp_q[i].idx, exp_q[i].body);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_body();
        bit ok;
        out_rdy = 1'b1;
        for (int i = 0; i < LWE_K; i++) send('0, 5'd1);
        send(64'h0010_0000_0000_0000, 5'd1);
        for (int i = 0; i < LWE_K; i++) send('0, 5'd1);
        send('0, 5'd1);
        drain(ok);
        vec_cnt++;
        if (!ok || got_q.size() != 2 * KP1) begin
            miss_cnt++;
            $display("FAIL body_count got %0d outputs want %0d", got_q.size(), 2 * KP1);
        end else begin
            vec_cnt += 3;
            if (got_q[KP1-1].coef !== 'hFFF || got_q[KP1-1].body !== 1 || got_q[KP1-1].idx !== LWE_K) begin
                miss_cnt++;
                $display("FAIL body_neg got coef=%03h body=%0d idx=%0d want coef=fff body=1 idx=%0d",
                         got_q[KP1-1].coef, got_q[KP1-1].body, got_q[KP1-1].idx, LWE_K);
            end
            if (got_q[2*KP1-1].coef !== 0 || got_q[2*KP1-1].body !== 1) begin
                miss_cnt++;
                $display("FAIL body_zero got coef=%03h body=%0d want coef=000 body=1",
                         got_q[2*KP1-1].coef, got_q[2*KP1-1].body);
            end
            if (got_q[KP1-2].body !== 0 || got_q[KP1-2].coef !== 0) begin
                miss_cnt++;
                $display("FAIL body_mask got coef=%03h body=%0d want coef=000 body=0",
                         got_q[KP1-2].coef, got_q[KP1-2].body);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int bodies = 0;
        out_rdy = 1'b1;
        send_ct(5'd3, KP1);
        send_ct(5'd7, KP1);
        drain(ok);
        vec_cnt++;
        if (!ok || got_q.size() != 2 * KP1) begin
            miss_cnt++;
            $display("FAIL b2b_count got %0d outputs want %0d", got_q.size(), 2 * KP1);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            bodies += got_q[i].body;
            vec_cnt += 3;
            if (got_q[i].idx !== i % KP1 || got_q[i].pid !== ((i < KP1) ? 3 : 7)) begin
                miss_cnt++;
                $display("FAIL b2b_tag[%0d] got idx=%0d pid=%0d want idx=%0d pid=%0d", i,
                         got_q[i].idx, got_q[i].pid, i % KP1, (i < KP1) ? 3 : 7);
            end
            if (got_q[i].cyc - exp_q[i].cyc !== 2) begin
                miss_cnt++;
                $display("FAIL b2b_latency[%0d] got %0d cycles want 2", i, got_q[i].cyc - exp_q[i].cyc);
            end
            if (got_q[i].coef !== exp_q[i].coef || got_q[i].body !== exp_q[i].body ||
                (i > 0 && got_q[i].cyc - got_q[i-1].cyc !== 1)) begin
                miss_cnt++;
                $display("FAIL b2b_model[%0d] got coef=%03h body=%0d want coef=%03h body=%0d (no bubble)",
                         i, got_q[i].coef, got_q[i].body, exp_q[i].coef, exp_q[i].body);
            end
        end
        vec_cnt++;
        if (bodies !== 2) begin
            miss_cnt++;
            $display("FAIL b2b_bodies got %0d body flags want 2", bodies);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_backpressure();
        bit ok;
        bit acc;
        int a0;
        out_rdy  = 1'b0;
        a0       = acc_cnt;
        in_pid   = 5'd9;
        in_coef  = {$urandom, $urandom};
        in_vld   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            acc = in_rdy;
            @(posedge clk);
            #1;
            if (acc) in_coef = {$urandom, $urandom};
        end
        vec_cnt += 3;
        if (acc_cnt - a0 !== OUT_DEPTH) begin
            miss_cnt++;
            $display("FAIL bp_accepts got %0d want %0d", acc_cnt - a0, OUT_DEPTH);
        end
        if (in_rdy !== 1'b0) begin miss_cnt++; $display("FAIL bp_in_rdy got %b want 0", in_rdy); end
        if (out_vld !== 1'b1) begin miss_cnt++; $display("FAIL bp_out_vld got %b want 1", out_vld); end
        in_vld   = 1'b0;
        rand_rdy = 1'b1;
        send_ct(5'd9, KP1 - m_idx);
        send_ct(5'd9, KP1);
        drain(ok);
        rand_rdy = 1'b0;
        out_rdy  = 1'b1;
        vec_cnt += 2;
        if (!ok || got_q.size() != exp_q.size()) begin
            miss_cnt++;
            $display("FAIL bp_count got %0d outputs want %0d", got_q.size(), exp_q.size());
        end
        if (stab_viol !== 0) begin
            miss_cnt++;
            $display("FAIL bp_stable got %0d changes while stalled want 0", stab_viol);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vec_cnt++;
            if (got_q[i].coef !== exp_q[i].coef || got_q[i].pid !== exp_q[i].pid ||
                got_q[i].idx !== exp_q[i].idx || got_q[i].body !== exp_q[i].body) begin
                miss_cnt++;
                $display("FAIL bp_model[%0d] got %03h/%0d/%0d/%0d want %03h/%0d/%0d/%0d", i,
                         got_q[i].coef, got_q[i].pid, got_q[i].idx, got_q[i].body,
                         exp_q[i].coef, exp_q[i].pid, exp_q[i].idx, exp_q[i].body);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_pid_err();
        bit ok;
        int e0 = err_seen;
        out_rdy = 1'b1;
        for (int i = 0; i < KP1; i++) send({$urandom, $urandom}, (i == 5) ? 5'd12 : 5'd4);
        drain(ok);
        vec_cnt += 2;
        if (err_seen - e0 !== 1) begin
            miss_cnt++;
            $display("FAIL pid_err_pulses got %0d want 1", err_seen - e0);
        end
        if (!ok || got_q.size() != KP1) begin
            miss_cnt++;
            $display("FAIL pid_count got %0d outputs want %0d", got_q.size(), KP1);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vec_cnt++;
            if (got_q[i].pid !== 4 || got_q[i].idx !== i || got_q[i].coef !== exp_q[i].coef) begin
                miss_cnt++;
                $display("FAIL pid_keep[%0d] got pid=%0d idx=%0d coef=%03h want pid=4 idx=%0d coef=%03h",
                         i, got_q[i].pid, got_q[i].idx, got_q[i].coef, i, exp_q[i].coef);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset_mid();
        bit ok;
        out_rdy = 1'b1;
        send_ct(5'd15, 11);
        for (int i = 0; i < got_q.size(); i++) begin
            vec_cnt++;
            if (got_q[i].coef !== exp_q[i].coef || got_q[i].idx !== exp_q[i].idx) begin
                miss_cnt++;
                $display("FAIL pre_rst[%0d] got coef=%03h idx=%0d want coef=%03h idx=%0d",
                         i, got_q[i].coef, got_q[i].idx, exp_q[i].coef, exp_q[i].idx);
            end
        end
        vec_cnt++;
        if (out_vld !== 1'b1) begin miss_cnt++; $display("FAIL pre_rst_vld got %b want 1", out_vld); end
        a_rst_n = 1'b0;
        #1;
        vec_cnt += 2;
        if (out_vld !== 1'b0) begin miss_cnt++; $display("FAIL mid_rst_vld got %b want 0", out_vld); end
        if (in_rdy !== 1'b0)  begin miss_cnt++; $display("FAIL mid_rst_rdy got %b want 0", in_rdy); end
        exp_q.delete();
        got_q.delete();
        m_idx = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a_rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_ct(5'd21, KP1);
        drain(ok);
        vec_cnt++;
        if (!ok || got_q.size() != KP1) begin
            miss_cnt++;
            $display("FAIL post_rst_count got %0d outputs want %0d", got_q.size(), KP1);
        end else begin
            vec_cnt++;
            if (got_q[0].idx !== 0 || got_q[0].pid !== 21 || got_q[KP1-1].body !== 1) begin
                miss_cnt++;
                $display("FAIL post_rst_first got idx=%0d pid=%0d last_body=%0d want idx=0 pid=21 last_body=1",
                         got_q[0].idx, got_q[0].pid, got_q[KP1-1].body);
            end
            for (int i = 0; i < KP1; i++) begin
                vec_cnt++;
                if (got_q[i].coef !== exp_q[i].coef || got_q[i].idx !== i) begin
                    miss_cnt++;
                    $display("FAIL post_rst[%0d] got coef=%03h idx=%0d want coef=%03h idx=%0d",
                             i, got_q[i].coef, got_q[i].idx, exp_q[i].coef, i);
                end
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_body();
        test_back_to_back();
        test_backpressure();
        test_pid_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/pep_mod_switch.md
Name: pep_mod_switch

Overview:
- Modulus-switch stage at the head of the PBS pipe, fed by the LWE input stream.
- Rounds each LWE coefficient from MOD_Q_W bits down to LWE_COEF_W bits (range [0,2N)), tags the body and forwards to blind-rotation sequencing.
- Tracks the coefficient index within each ciphertext of LWE_K_P1 coefficients (mask 0..LWE_K-1, then body at LWE_K).
- An elastic output buffer decouples the input from downstream backpressure.

Parameters:
- PID_W, 5, width of PBS identifier carried with each ciphertext
- OUT_DEPTH, 4, output FIFO depth; power of 2, >=2
- BODY_NEG, 1, 1: output body as (-round(b)) mod 2N; 0: output body unmodified
- TFHE constants (N, LWE_K, MOD_Q_W, MOD_Q, LWE_COEF_W, LWE_K_P1_W) come from param_tfhe_pkg, not module parameters.

Ports:
- clk, in, 1, clock
- a_rst_n, in, 1, asynchronous active-low reset
- in_coef, in, MOD_Q_W, input LWE coefficient
- in_pid, in, PID_W, PBS id of the ciphertext being streamed
- in_vld, in, 1, input valid
- in_rdy, out, 1, input ready
- out_coef, out, LWE_COEF_W, switched coefficient
- out_pid, out, PID_W, PBS id latched at index 0
- out_idx, out, LWE_K_P1_W, coefficient index 0..LWE_K
- out_body, out, 1, high when out_idx==LWE_K
- out_vld, out, 1, output valid
- out_rdy, in, 1, output ready
- err_pid, out, 1, one-cycle pulse on pid mismatch mid-ciphertext

Behaviour:
- Reset: clk single clock domain; a_rst_n asynchronous active-low. While low: out_vld=0, err_pid=0, in_rdy=0. Index counter=0, FIFO empty, S1 empty.
- Accept: occurs on in_vld && in_rdy. in_rdy = (fifo_cnt + s1_vld) < OUT_DEPTH (combinational from registers only, not from in_vld/out_rdy). in_rdy=1 first cycle after reset release.
- Rounding: S = MOD_Q_W - LWE_COEF_W. r = (in_coef[MOD_Q_W-1:S] + in_coef[S-1]) mod 2^LWE_COEF_W. Carry out of the top bit is dropped (wrap to 0).
- Body: if idx==LWE_K and BODY_NEG=1, out = (2^LWE_COEF_W - r) mod 2^LWE_COEF_W, so r=0 gives 0.
- MOD_Q != 2**MOD_Q_W or S<1: elaboration-time $fatal.
- Pipeline:
  - Stage S1 registers {r, pid, idx, body} on accept.
  - S1 writes the FIFO the next cycle unconditionally; in_rdy guarantees space.
  - FIFO is show-ahead; out_vld = !empty; pop on out_vld && out_rdy.
  - Latency: accept at cycle t -> out_vld at t+2 when the FIFO is empty. Throughput 1/cycle while out_rdy=1.
- Index counter:
  - Increments per accept. After LWE_K it wraps to 0 on the next accept.
  - Latches in_pid into pid_q when accepting idx 0.
  - For idx!=0, if in_pid!=pid_q: err_pid pulses the cycle after accept. The coefficient still passes with pid_q; the counter is unaffected.
- Simultaneous S1 write and FIFO pop: fifo_cnt unchanged; full case is legal.
- out_* hold stable while out_vld && !out_rdy.
- Reset mid-ciphertext: partial data discarded. The next accepted coefficient is idx 0 with a freshly latched pid.
- No output is ever produced with idx outside 0..LWE_K.

Decomposition:
- Additions to param_tfhe_pkg:
  - MS_SHIFT = MOD_Q_W - LWE_COEF_W.
  - Body-position constant LWE_BODY_IDX = LWE_K.
- Add a pep_ms_pkg holding typedef ms_data_t {coef LWE_COEF_W, pid PID_W, idx LWE_K_P1_W, body}.
- One sub-module: pep_ms_ofifo. Register-based show-ahead FIFO of ms_data_t, depth OUT_DEPTH, with count output. Rounding, counter and S1 stay in pep_mod_switch.

Test Plan:
- Rounding: MOD_Q_W=64, N=2048 (LWE_COEF_W=12), idx 0, in_coef=0x0008_0000_0000_0000 -> out_coef=0x001. in_coef=0x0007_FFFF_FFFF_FFFF -> 0x000.
- Wrap: in_coef=0xFFF8_0000_0000_0000 at idx 0 -> out_coef=0x000. in_coef=0xFFF0_0000_0000_0000 -> 0xFFF.
- Body negation: stream LWE_K masks of 0, then body 0x0010_0000_0000_0000, BODY_NEG=1 -> last output out_coef=0xFFF, out_body=1, out_idx=LWE_K. Body 0 -> 0x000.
- Indexing: stream 2*(LWE_K+1) coefficients back-to-back with pid 3 then pid 7, out_rdy=1. Expect out_idx 0..LWE_K twice. out_body high exactly twice. out_pid 3 then 7. Latency 2 cycles. No bubbles.
- Backpressure: out_rdy=0, in_vld=1 continuously, OUT_DEPTH=4 -> exactly 4 accepts, then in_rdy=0. Raise out_rdy -> data in order, no loss or duplication.
- Errors/reset:
  - Change in_pid at idx 5 -> err_pid single pulse; out_pid keeps the original.
  - Assert a_rst_n low at idx 10 -> out_vld=0 immediately. After release, first output has out_idx=0.
